// File: rtl/servo_pwm_multi_if.sv
// Purpose: command write bus from the motion sequencer into the servo pulse generator.
// Latency: none; this only groups signals (one write per cycle while wr_en is high).
// Backpressure: none; the generator accepts a write every cycle.
interface servo_pwm_multi_if #(
    parameter int NUM_CH  = 4,
    parameter int ANGLE_W = 9
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic               wr_en;    // one-cycle command strobe
    logic [CH_W-1:0]    wr_ch;    // target channel
    logic [ANGLE_W-1:0] wr_cmd;   // angle (positional) or speed code (continuous)
    logic               wr_cont;  // 1 = continuous-rotation mode
    logic               wr_on;    // 1 = enable channel

    modport master (output wr_en, wr_ch, wr_cmd, wr_cont, wr_on);
    modport slave  (input  wr_en, wr_ch, wr_cmd, wr_cont, wr_on);
endinterface

// File: rtl/servo_pwm_multi.sv
// Purpose: multi-channel servo PWM generator with per-frame slew limiting for positional channels.
// Latency: a command is captured in its write cycle and takes effect at the next frame boundary.
// Backpressure: none; writes are always accepted, and a later write to a channel overrides an earlier one.
// Ports: clk, rst_n (async, active low); cmd (slave write bus); pwm[NUM_CH] pulse outputs;
//        frame_start (one-cycle pulse per frame); settled[NUM_CH] (enabled and width at target).
module servo_pwm_multi #(
    parameter int NUM_CH        = 4,
    parameter int ANGLE_W       = 9,
    parameter int FRAME_CYCLES  = 2000000,
    parameter int POS_MIN       = 60000,
    parameter int DEG_SCALE     = 1000,
    parameter int MAX_ANGLE     = 180,
    parameter int CONT_MIN      = 100000,
    parameter int CONT_SCALE    = 50000,
    parameter int CONT_MAX_CODE = 2,
    parameter int RAMP_STEP     = 2000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    servo_pwm_multi_if.slave     cmd,
    output logic [NUM_CH-1:0]    pwm,
    output logic                 frame_start,
    output logic [NUM_CH-1:0]    settled
);
    localparam int PW_W = $clog2(FRAME_CYCLES);
    localparam int CW   = PW_W + ANGLE_W;

    localparam logic [PW_W-1:0] PW_CENTER = PW_W'(POS_MIN + 90 * DEG_SCALE);
    localparam logic [PW_W-1:0] LAST_CNT  = PW_W'(FRAME_CYCLES - 1);
    localparam logic [PW_W-1:0] STEP      = PW_W'(RAMP_STEP);

    logic [PW_W-1:0] cnt;
    logic            boundary;

    // Per-channel shadow (written by commands) and live state (updated at boundaries).
    logic [PW_W-1:0]   tgt     [NUM_CH];
    logic [PW_W-1:0]   cur     [NUM_CH];
    logic [PW_W-1:0]   cur_nxt [NUM_CH];
    logic [NUM_CH-1:0] cont_mode;
    logic [NUM_CH-1:0] on;
    logic [NUM_CH-1:0] en;
    logic [NUM_CH-1:0] armed;     // set while the servo position is unknown

    logic [ANGLE_W-1:0] cmd_clamped;
    logic [CW-1:0]      tgt_wide;
    logic [PW_W-1:0]    tgt_new;

    assign boundary = (cnt == LAST_CNT);

    // Clamp the raw code first, then scale at full width so nothing wraps before the clamp.
    always_comb begin
        cmd_clamped = cmd.wr_cmd;
        tgt_wide    = '0;
        if (cmd.wr_cont) begin
            if (cmd.wr_cmd > ANGLE_W'(CONT_MAX_CODE))
                cmd_clamped = ANGLE_W'(CONT_MAX_CODE);
            tgt_wide = CW'(CONT_MIN) + CW'(cmd_clamped) * CW'(CONT_SCALE);
        end else begin
            if (cmd.wr_cmd > ANGLE_W'(MAX_ANGLE))
                cmd_clamped = ANGLE_W'(MAX_ANGLE);
            tgt_wide = CW'(POS_MIN) + CW'(cmd_clamped) * CW'(DEG_SCALE);
        end
    end

    assign tgt_new = PW_W'(tgt_wide);

    // Next width at the boundary. Differences are compared instead of sums so
    // the unsigned arithmetic can neither overflow nor underflow past the target.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            cur_nxt[i] = cur[i];
            if (cont_mode[i] || armed[i])
                cur_nxt[i] = tgt[i];
            else if (tgt[i] > cur[i])
                cur_nxt[i] = ((tgt[i] - cur[i]) > STEP) ? cur[i] + STEP : tgt[i];
            else if (tgt[i] < cur[i])
                cur_nxt[i] = ((cur[i] - tgt[i]) > STEP) ? cur[i] - STEP : tgt[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (boundary)
            cnt <= '0;
        else
            cnt <= cnt + PW_W'(1);
    end

    // Boundary logic reads the pre-write shadow because both updates are
    // non-blocking; a write in the boundary cycle lands for the next frame.
    // Writes to channels >= NUM_CH match no loop index and are dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                tgt[i] <= PW_CENTER;
                cur[i] <= PW_CENTER;
            end
            cont_mode <= '0;
            on        <= '0;
            en        <= '0;
            armed     <= '1;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (boundary) begin
                    if (!on[i]) begin
                        en[i]    <= 1'b0;
                        armed[i] <= 1'b1;
                    end else begin
                        cur[i]   <= cur_nxt[i];
                        en[i]    <= 1'b1;
                        armed[i] <= 1'b0;
                    end
                end
                if (cmd.wr_en && (int'(cmd.wr_ch) == i)) begin
                    tgt[i]       <= tgt_new;
                    cont_mode[i] <= cmd.wr_cont;
                    on[i]        <= cmd.wr_on;
                end
            end
        end
    end

    // cnt < cur is never true for cur == 0, so a zero width gives no pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm         <= '0;
            frame_start <= 1'b0;
            settled     <= '0;
        end else begin
            frame_start <= (cnt == '0);
            for (int i = 0; i < NUM_CH; i++) begin
                pwm[i]     <= en[i] && (cnt < cur[i]);
                settled[i] <= en[i] && (cur[i] == tgt[i]);
            end
        end
    end
endmodule
